// File: rtl/alu_engine_apb.sv
// APB-attached ALU engine: command queue, 3-state execute FSM with shift-add multiplier,
// and an id-tagged result queue. Zero-wait slave with flush control.
module alu_engine_apb #(
  parameter int unsigned DATA_SIZE     = 16,
  parameter int unsigned ID_SIZE       = 8,
  parameter int unsigned APB_BUS_SIZE  = 32,
  parameter int unsigned ADDRESS_SIZE  = 3,
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned RES_DEPTH     = 4,
  parameter int unsigned MUL_DATA_SIZE = DATA_SIZE / 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    en,
  input  logic                    write,
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic [APB_BUS_SIZE-1:0] wdata,
  output logic                    ready,
  output logic                    slv_err,
  output logic [APB_BUS_SIZE-1:0] rdata
);
  localparam int unsigned CPW = $clog2(CMD_DEPTH);
  localparam int unsigned RPW = $clog2(RES_DEPTH);
  localparam int unsigned SHW = $clog2(DATA_SIZE);
  localparam int unsigned MCW = $clog2(MUL_DATA_SIZE);

  localparam logic [ADDRESS_SIZE-1:0] AddrCtrl   = ADDRESS_SIZE'(0);
  localparam logic [ADDRESS_SIZE-1:0] AddrOp0    = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE-1:0] AddrOp1    = ADDRESS_SIZE'(2);
  localparam logic [ADDRESS_SIZE-1:0] AddrRes    = ADDRESS_SIZE'(3);
  localparam logic [ADDRESS_SIZE-1:0] AddrStatus = ADDRESS_SIZE'(4);

  typedef enum logic [2:0] {OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpShl, OpShr} op_e;
  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  typedef struct packed {
    op_e                  op;
    logic [ID_SIZE-1:0]   id;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [ID_SIZE-1:0]   id;
    logic                 c;
    logic [DATA_SIZE-1:0] r;
  } res_t;

  state_e               state_q, state_d;
  logic [29:0]          ctrl_q;
  logic [DATA_SIZE-1:0] op0_q, op1_q;
  cmd_t                 cmd_mem [CMD_DEPTH];
  res_t                 res_mem [RES_DEPTH];
  logic [CPW-1:0]       cmd_wr_q, cmd_rd_q;
  logic [CPW:0]         cmd_count_q;
  logic [RPW-1:0]       res_wr_q, res_rd_q;
  logic [RPW:0]         res_count_q;
  cmd_t                 cur_q, new_cmd;
  res_t                 res_head;
  logic [DATA_SIZE-1:0] acc_q, alu_res, mul_add;
  logic                 carry_q, alu_c;
  logic [MCW-1:0]       mul_cnt_q;

  logic access, wr, rd, ctrl_wr, flush, push_req, push, res_pop, cmd_pop, wb_write;
  logic cmd_full, cmd_empty, res_full, res_empty, exec_done;

  assign ready     = 1'b1;
  assign cmd_full  = cmd_count_q == (CPW+1)'(CMD_DEPTH);
  assign cmd_empty = cmd_count_q == '0;
  assign res_full  = res_count_q == (RPW+1)'(RES_DEPTH);
  assign res_empty = res_count_q == '0;

  assign access   = sel & en;
  assign wr       = access & write;
  assign rd       = access & ~write;
  assign ctrl_wr  = wr & (addr == AddrCtrl);
  assign flush    = ctrl_wr & wdata[30];
  assign push_req = ctrl_wr & wdata[31] & ~wdata[30];
  assign push     = push_req & ~cmd_full;
  assign res_pop  = rd & (addr == AddrRes) & ~res_empty;
  // Flush wins over any FSM queue activity on the same edge.
  assign cmd_pop  = (state_q == StIdle) & ~cmd_empty & ~flush;
  assign wb_write = (state_q == StWb) & ~res_full & ~flush;

  assign new_cmd  = '{op: op_e'(wdata[2:0]), id: wdata[8 +: ID_SIZE], a: op0_q, b: op1_q};
  assign res_head = res_mem[res_rd_q];

  assign exec_done = (cur_q.op != OpMul) || (mul_cnt_q == MCW'(MUL_DATA_SIZE - 1));
  assign mul_add   = cur_q.b[mul_cnt_q] ?
                     (DATA_SIZE'(cur_q.a[MUL_DATA_SIZE-1:0]) << mul_cnt_q) : '0;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (cur_q.op)
      OpAdd:   {alu_c, alu_res} = {1'b0, cur_q.a} + {1'b0, cur_q.b};
      OpSub: begin
        alu_res = cur_q.a - cur_q.b;
        alu_c   = cur_q.a < cur_q.b;
      end
      OpAnd:   alu_res = cur_q.a & cur_q.b;
      OpOr:    alu_res = cur_q.a | cur_q.b;
      OpXor:   alu_res = cur_q.a ^ cur_q.b;
      OpShl:   alu_res = cur_q.a << cur_q.b[SHW-1:0];
      OpShr:   alu_res = cur_q.a >> cur_q.b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!cmd_empty) state_d = StExec;
      StExec:  if (exec_done) state_d = StWb;
      StWb:    if (!res_full) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      op0_q  <= '0;
      op1_q  <= '0;
    end else begin
      if (ctrl_wr) ctrl_q <= wdata[29:0];
      if (wr && addr == AddrOp0) op0_q <= wdata[DATA_SIZE-1:0];
      if (wr && addr == AddrOp1) op1_q <= wdata[DATA_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push)     cmd_mem[cmd_wr_q] <= new_cmd;
    if (wb_write) res_mem[res_wr_q] <= '{id: cur_q.id, c: carry_q, r: acc_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_count_q <= '0;
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      res_count_q <= '0;
    end else if (flush) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_count_q <= '0;
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      res_count_q <= '0;
    end else begin
      if (push)     cmd_wr_q <= cmd_wr_q + CPW'(1);
      if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CPW'(1);
      if (push && !cmd_pop)      cmd_count_q <= cmd_count_q + (CPW+1)'(1);
      else if (!push && cmd_pop) cmd_count_q <= cmd_count_q - (CPW+1)'(1);
      if (wb_write) res_wr_q <= res_wr_q + RPW'(1);
      if (res_pop)  res_rd_q <= res_rd_q + RPW'(1);
      if (wb_write && !res_pop)      res_count_q <= res_count_q + (RPW+1)'(1);
      else if (!wb_write && res_pop) res_count_q <= res_count_q - (RPW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      mul_cnt_q <= '0;
    end else if (cmd_pop) begin
      cur_q     <= cmd_mem[cmd_rd_q];
      acc_q     <= '0;
      carry_q   <= 1'b0;
      mul_cnt_q <= '0;
    end else if (state_q == StExec) begin
      if (cur_q.op == OpMul) begin
        acc_q     <= acc_q + mul_add;
        mul_cnt_q <= mul_cnt_q + MCW'(1);
      end else begin
        acc_q   <= alu_res;
        carry_q <= alu_c;
      end
    end
  end

  // Errors are judged on pre-edge state.
  always_comb begin
    slv_err = 1'b0;
    if (access) begin
      case (addr)
        AddrCtrl:         slv_err = push_req & cmd_full;
        AddrOp0, AddrOp1: slv_err = 1'b0;
        AddrRes:          slv_err = write | res_empty;
        AddrStatus:       slv_err = write;
        default:          slv_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        AddrCtrl: rdata[29:0] = ctrl_q;
        AddrOp0:  rdata[DATA_SIZE-1:0] = op0_q;
        AddrOp1:  rdata[DATA_SIZE-1:0] = op1_q;
        AddrRes: begin
          if (!res_empty) begin
            rdata[DATA_SIZE-1:0]  = res_head.r;
            rdata[DATA_SIZE]      = res_head.c;
            rdata[24 +: ID_SIZE]  = res_head.id;
          end
        end
        AddrStatus: begin
          rdata[0]            = cmd_full;
          rdata[1]            = cmd_empty;
          rdata[2]            = res_full;
          rdata[3]            = res_empty;
          rdata[4]            = state_q != StIdle;
          rdata[8 +: CPW+1]   = cmd_count_q;
          rdata[16 +: RPW+1]  = res_count_q;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_engine_apb.sv
// Self-checking bench for alu_engine_apb: vector table plus cycle-exact sequences for
// latency, queue full/stall, error, flush and asynchronous reset behaviour.
module tb_alu_engine_apb;
  logic        clk = 1'b0;
  logic        rst, sel, en, write, ready, slv_err;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  id;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_engine_apb dut (
    .clk(clk), .rst(rst), .sel(sel), .en(en), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .slv_err(slv_err), .rdata(rdata)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] id);
    logic [16:0] t;
    case (op)
      3'd0:    t = {1'b0, a} + {1'b0, b};
      3'd1:    t = {(a < b), 16'(a - b)};
      3'd2:    t = 17'(a[7:0]) * 17'(b[7:0]);
      3'd3:    t = {1'b0, a & b};
      3'd4:    t = {1'b0, a | b};
      3'd5:    t = {1'b0, a ^ b};
      3'd6:    t = {1'b0, 16'(a << b[3:0])};
      default: t = {1'b0, 16'(a >> b[3:0])};
    endcase
    return {id, 7'b0, t};
  endfunction

  // Setup phase then access phase; outputs sampled mid access phase.
  task automatic apb(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic e);
    @(negedge clk);
    sel = 1'b1; en = 1'b0; write = w; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b1;
    #1;
    r = rdata;
    e = slv_err;
    @(posedge clk);
    #1;
    sel = 1'b0; en = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] id);
    wr(3'd1, {16'h0, a});
    wr(3'd2, {16'h0, b});
    wr(3'd0, 32'h8000_0000 | {16'h0, id, 5'h0, op});
  endtask

  task automatic status_is(input string name, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, 3'd4, 32'h0, r, e);
    check(name, r, exp);
  endtask

  task automatic wait_result(input string name);
    logic [31:0] r;
    logic e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      apb(1'b0, 3'd4, 32'h0, r, e);
      if (r[23:16] != 8'h0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_wait: res_count stayed 0, required nonzero within 40 polls", name);
    end
  endtask

  task automatic drain_one(input string name);
    logic [31:0] r, exp;
    logic e;
    wait_result(name);
    apb(1'b0, 3'd3, 32'h0, r, e);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected result %h, required none", name, r);
    end else begin
      exp = sb_q.pop_front();
      check(name, r, exp);
    end
    check({name, "_err"}, 32'(e), 32'h0);
  endtask

  // Holds a STATUS read open so each cycle's post-edge state can be sampled.
  task automatic watch_status(input string name, input int k_max, input logic [31:0] exp_tab[]);
    sel = 1'b1; en = 1'b1; write = 1'b0; addr = 3'd4;
    #1;
    check($sformatf("%s_k0", name), rdata, exp_tab[0]);
    for (int k = 1; k <= k_max; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_k%0d", name, k), rdata, exp_tab[k]);
    end
    sel = 1'b0; en = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    logic [31:0] add_tab[], mul_tab[];

    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 8'h2A, 32'h2A01_0000};
    vecs[1]  = '{3'd0, 16'h1234, 16'h1111, 8'h01, 32'h0100_2345};
    vecs[2]  = '{3'd1, 16'h0005, 16'h0007, 8'h02, 32'h0201_FFFE};
    vecs[3]  = '{3'd1, 16'h0009, 16'h0004, 8'h03, 32'h0300_0005};
    vecs[4]  = '{3'd2, 16'h00FF, 16'h00FF, 8'h07, 32'h0700_FE01};
    vecs[5]  = '{3'd2, 16'h1203, 16'hAB05, 8'h08, 32'h0800_000F};
    vecs[6]  = '{3'd3, 16'hF0F0, 16'h3C3C, 8'h09, 32'h0900_3030};
    vecs[7]  = '{3'd4, 16'hF0F0, 16'h0F01, 8'h0A, 32'h0A00_FFF1};
    vecs[8]  = '{3'd5, 16'hAAAA, 16'hFFFF, 8'h0B, 32'h0B00_5555};
    vecs[9]  = '{3'd6, 16'h0001, 16'h0014, 8'h0C, 32'h0C00_0010};
    vecs[10] = '{3'd7, 16'h8000, 16'h000F, 8'h0D, 32'h0D00_0001};
    vecs[11] = '{3'd6, 16'h00FF, 16'h0108, 8'h0E, 32'h0E00_FF00};

    rst = 1'b1; sel = 1'b0; en = 1'b0; write = 1'b0; addr = 3'd0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_slv_err", 32'(slv_err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    status_is("rst_status", 32'h0000_000A);
    apb(1'b0, 3'd0, 32'h0, r, e); check("rst_ctrl", r, 32'h0);
    apb(1'b0, 3'd1, 32'h0, r, e); check("rst_op0", r, 32'h0);

    // ADD: result visible after the third edge following the push
    wr(3'd1, 32'h0000_FFFF);
    wr(3'd2, 32'h0000_0001);
    apb(1'b1, 3'd0, 32'h8000_2A00, r, e);
    check("add_push_err", 32'(e), 32'h0);
    sb_q.push_back(32'h2A01_0000);
    add_tab = '{32'h0000_0108, 32'h0000_001A, 32'h0000_001A, 32'h0001_0002};
    watch_status("add_lat", 3, add_tab);
    drain_one("add_res");

    // MUL: busy for the whole operation, result after edge 10
    wr(3'd1, 32'h0000_00FF);
    wr(3'd2, 32'h0000_00FF);
    apb(1'b1, 3'd0, 32'h8000_0702, r, e);
    sb_q.push_back(32'h0700_FE01);
    mul_tab = new[11];
    mul_tab[0] = 32'h0000_0108;
    for (int k = 1; k <= 9; k++) mul_tab[k] = 32'h0000_001A;
    mul_tab[10] = 32'h0001_0002;
    watch_status("mul_lat", 10, mul_tab);
    drain_one("mul_res");

    foreach (vecs[i]) begin
      push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].id);
      sb_q.push_back(vecs[i].exp);
      drain_one($sformatf("vec%0d", i));
    end

    // Command queue full: engine busy on a MUL, then 5 back-to-back pushes
    push_cmd(3'd2, 16'h0003, 16'h0005, 8'h01);
    sb_q.push_back(model(3'd2, 16'h0003, 16'h0005, 8'h01));
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b1; en = 1'b1; write = 1'b1; addr = 3'd0;
    for (int k = 0; k < 5; k++) begin
      wdata = 32'h8000_0002 | (32'(k + 2) << 8);
      #1;
      check($sformatf("full_push%0d_err", k), 32'(slv_err), (k == 4) ? 32'h1 : 32'h0);
      if (k < 4) sb_q.push_back(model(3'd2, 16'h0003, 16'h0005, 8'(k + 2)));
      @(posedge clk);
      #1;
    end
    sel = 1'b0; en = 1'b0; write = 1'b0;
    status_is("full_status", 32'h0000_0419);
    for (int i = 0; i < 5; i++) drain_one($sformatf("full_res%0d", i));
    repeat (30) @(posedge clk);
    status_is("full_dropped", 32'h0000_000A);

    // Result queue stall and release
    for (int i = 0; i < 6; i++) begin
      push_cmd(3'd0, 16'h0100, 16'h0023, 8'(8'h20 + i));
      sb_q.push_back(model(3'd0, 16'h0100, 16'h0023, 8'(8'h20 + i)));
    end
    repeat (40) @(posedge clk);
    status_is("stall_status", 32'h0004_0114);
    apb(1'b0, 3'd3, 32'h0, r, e);
    check("stall_pop", r, sb_q.pop_front());
    status_is("stall_release", 32'h0004_0104);
    for (int i = 0; i < 5; i++) drain_one($sformatf("stall_res%0d", i));
    repeat (20) @(posedge clk);
    status_is("stall_done", 32'h0000_000A);

    wr(3'd0, 32'h4000_1F05);
    apb(1'b0, 3'd0, 32'h0, r, e); check("ctrl_readback", r, 32'h0000_1F05);

    // Error accesses leave state untouched
    apb(1'b0, 3'd3, 32'h0, r, e);
    check("res_empty_rdata", r, 32'h0);
    check("res_empty_err", 32'(e), 32'h1);
    apb(1'b1, 3'd4, 32'hFFFF_FFFF, r, e); check("wr_status_err", 32'(e), 32'h1);
    apb(1'b1, 3'd3, 32'hFFFF_FFFF, r, e); check("wr_res_err", 32'(e), 32'h1);
    apb(1'b1, 3'd6, 32'hFFFF_FFFF, r, e); check("wr_addr6_err", 32'(e), 32'h1);
    apb(1'b0, 3'd6, 32'h0, r, e);
    check("rd_addr6_err", 32'(e), 32'h1);
    check("rd_addr6_rdata", r, 32'h0);
    status_is("err_status", 32'h0000_000A);
    apb(1'b0, 3'd0, 32'h0, r, e); check("err_ctrl_kept", r, 32'h0000_1F05);
    apb(1'b0, 3'd1, 32'h0, r, e); check("err_op0_kept", r, 32'h0000_0100);

    // Flush during MUL with a second command queued
    push_cmd(3'd2, 16'h00FF, 16'h00FF, 8'h31);
    wr(3'd0, 32'h8000_3202);
    repeat (2) @(posedge clk);
    wr(3'd0, 32'h4000_0000);
    status_is("flush_status", 32'h0000_000A);
    repeat (20) @(posedge clk);
    status_is("flush_no_result", 32'h0000_000A);

    // Flush overrides a push in the same write
    push_cmd(3'd2, 16'h00FF, 16'h00FF, 8'h33);
    repeat (3) @(posedge clk);
    wr(3'd0, 32'hC000_0305);
    repeat (20) @(posedge clk);
    status_is("flush_push_status", 32'h0000_000A);
    apb(1'b0, 3'd0, 32'h0, r, e); check("flush_ctrl_read", r, 32'h0000_0305);

    // Asynchronous reset in the middle of EXEC
    push_cmd(3'd2, 16'h00FF, 16'h00FF, 8'h40);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b1; en = 1'b1; write = 1'b0; addr = 3'd4;
    #1;
    check("pre_rst_busy", rdata, 32'h0000_001A);
    #1 rst = 1'b1;
    #1;
    check("async_rst_status", rdata, 32'h0000_000A);
    sel = 1'b0; en = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_ready", 32'(ready), 32'h1);
    check("async_rst_err", 32'(slv_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    status_is("post_rst_status", 32'h0000_000A);
    apb(1'b0, 3'd1, 32'h0, r, e); check("post_rst_op0", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_engine_apb.md
# alu_engine_apb

Second-generation APB-attached ALU engine: a single-module replacement for the CSR / input FIFO / adder / multiplier / output FIFO chain. Supports eight opcodes over a parametrised data width, with an internal command queue, a result queue tagged with a command ID, a shift-add multiplier and a flush control. It sits directly on the APB bus as a slave with zero-wait transfers.

## Interface
- DATA_SIZE, 16: operand width; even, ≥4.
- ID_SIZE, 8: command tag width; ≤8.
- APB_BUS_SIZE, 32: APB data width.
- ADDRESS_SIZE, 3: APB address width.
- CMD_DEPTH, 4: command queue entries; power of 2, ≥2.
- RES_DEPTH, 4: result queue entries; power of 2, ≥2.
- MUL_DATA_SIZE, DATA_SIZE/2: multiplier operand width; also the multiply iteration count.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- sel, en, write  in  1 each: APB select, enable, direction.
- addr  in  ADDRESS_SIZE: register index.
- wdata  in  APB_BUS_SIZE: write data.
- ready  out  1: tied 1 (zero wait).
- slv_err  out  1: error flag, valid in the access phase (sel & en).
- rdata  out  APB_BUS_SIZE: read data; 0 when not reading.

## Operation
- Access: an access occurs on a rising edge with sel & en. Register side effects occur on that edge.
- Register map:
  - 0 CTRL (R/W): fields are [2:0] op, [15:8] id, [30] flush, [31] push. Reads return the last written value with bits 31:30 reading 0.
  - 1 OP0 (R/W): [DATA_SIZE-1:0].
  - 2 OP1 (R/W): [DATA_SIZE-1:0].
  - 3 RES (RO, pop): [DATA_SIZE-1:0] result, [DATA_SIZE] carry, [31:24] id.
  - 4 STATUS (RO): [0] cmd_full, [1] cmd_empty, [2] res_full, [3] res_empty, [4] busy (FSM≠IDLE), [15:8] cmd_count, [23:16] res_count.
  - 5–7: reserved.
- slv_err rules:
  - Push with cmd_full: the command is dropped.
  - RES read with res_empty: rdata=0 and no pop.
  - Write to RES or STATUS.
  - Any access to 5–7.
  - slv_err is combinational from the pre-edge state.
- Push: a CTRL write with bit31=1 enqueues {op, id, OP0, OP1}, using OP0/OP1 values before this edge.
- Flush: a CTRL write with bit30=1 empties both queues and returns the FSM to IDLE, discarding any in-flight command. Flush overrides push in the same write.
- Opcodes (r is DATA_SIZE wide, c is 1 bit):
  - 0 ADD: {c,r}=a+b.
  - 1 SUB: r=a−b, c=borrow (a<b).
  - 2 MUL: r=a[MUL_DATA_SIZE-1:0]×b[MUL_DATA_SIZE-1:0], c=0.
  - 3 AND, 4 OR, 5 XOR: c=0.
  - 6 SHL, 7 SHR: logical shift of a by b[$clog2(DATA_SIZE)-1:0], c=0.
- FSM states and transitions:
  - IDLE: if cmd queue non-empty, pop it, latch the operands and go to EXEC.
  - EXEC, non-MUL: compute and go to WB after 1 cycle.
  - EXEC, MUL: shift-add one bit per cycle, counter 0..MUL_DATA_SIZE−1, go to WB after MUL_DATA_SIZE cycles.
  - WB: if res queue not full (pre-edge), write the result and go to IDLE; otherwise hold in WB (stall).
- Queues: circular, with pointer wrap at DEPTH. Counts are $clog2(DEPTH)+1 bits.
- Simultaneous events:
  - Command queue: an APB push and an FSM pop on the same edge are both performed; the full check uses the pre-edge state, so a push at full is rejected even if a pop occurs.
  - Result queue: an APB pop and a WB write on the same edge are both performed; the count is unchanged.
  - WB stalled on full with a pop on the same edge: the write is taken on the next edge.

## Timing
- Reset values: ready=1, slv_err=0, rdata=0, queues empty, FSM=IDLE, CTRL/OP0/OP1=0, STATUS reads 0x0000_000A.
- Reset mid-operation clears all state immediately (asynchronous). There is no partial result.
- Latency, push edge E0 to result visible in res_count:
  - Non-MUL: after E3 (E1 pop, E2 EXEC, E3 WB).
  - MUL: after E(2+MUL_DATA_SIZE), i.e. 10 cycles at default.
- Throughput:
  - Non-MUL: one command per 3 cycles.
  - MUL: one per MUL_DATA_SIZE+2 cycles.
- Ordering: results leave in command order.
- RES read: rdata shows the head entry combinationally in the access phase; the pop occurs at the end of the access.

## Test plan
- ADD: OP0=0xFFFF, OP1=0x0001, CTRL=0x8000_2A00 -> after 3 cycles res_count=1; RES reads 0x2A01_0000 (carry=1, r=0, id=0x2A); slv_err=0.
- MUL: OP0=0x00FF, OP1=0x00FF, op=2, id=7 -> RES=0x0700_FE01 exactly 10 cycles after the push; busy=1 throughout.
- Command-queue full: 5 pushes of op=2 on back-to-back accesses with the engine busy -> 5th push slv_err=1 and dropped; 4 results returned in id order.
- Result-queue stall: push 6 ADDs without reading -> res_full=1 and FSM holds in WB with cmd_count=1; one RES read releases WB on the next edge; no result lost.
- Errors: read RES when empty -> slv_err=1, rdata=0; write STATUS, or access addr 6 -> slv_err=1, no state change.
- Flush and reset: flush (CTRL=0x4000_0000) during MUL -> STATUS=0x0A, no result produced; assert rst mid-EXEC -> all outputs at reset values within the same cycle.
